sm_ldm_stm_sequencer: RTL

Multi-cycle sequencer for block load/store (LDM/STM) instructions. It sits directly upstream of the three-read/one-write register file. It walks a 16-bit register list, drives a register-file read address for store data and the register-file write port for load data and base writeback, and runs a simple request/ready memory handshake. While it runs, the core pipeline stalls on `busy`.

---
 rtl/sm_ldm_stm_sequencer.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/sm_ldm_stm_sequencer.sv
// Block load/store (LDM/STM) sequencer: walks a 16-bit register list, drives the
// register-file ports and a request/ready memory handshake, and writes back the base.
module sm_ldm_stm_sequencer (
  input  logic        clk,
  input  logic        rst_p,
  input  logic        start,
  input  logic        load,
  input  logic        pre,
  input  logic        up,
  input  logic        wback,
  input  logic [3:0]  rn,
  input  logic [15:0] reg_list,
  input  logic [31:0] base_value,
  output logic [3:0]  rf_rd_addr,
  input  logic [31:0] rf_rd_data,
  output logic [3:0]  rf_wa,
  output logic [31:0] rf_wd,
  output logic        rf_we,
  output logic        pc_load,
  output logic [31:0] pc_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_XFER, S_WB, S_DONE} state_t;

  state_t      state;
  logic        load_q, pre_q, up_q, wback_q, base_in_list_q;
  logic [3:0]  rn_q, cur_q;
  logic [15:0] list_q;
  logic [31:0] base_q, wb_val_q;
  logic [4:0]  n_q;

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] c;
    c = 5'd0;
    for (int i = 0; i < 16; i++) c = c + {4'd0, v[i]};
    return c;
  endfunction

  function automatic logic [3:0] lowest16(input logic [15:0] v);
    logic [3:0] r;
    r = 4'd0;
    for (int i = 15; i >= 0; i--) if (v[i]) r = 4'(i);
    return r;
  endfunction

  logic [4:0]  n_c;
  logic [31:0] n4, start_addr;
  logic [15:0] list_nxt;

  assign n_c      = popcount16(list_q);
  assign n4       = {25'd0, n_c, 2'b00};
  assign list_nxt = list_q & ~(16'h0001 << cur_q);

  always_comb begin
    case ({pre_q, up_q})
      2'b01:   start_addr = base_q;
      2'b11:   start_addr = base_q + 32'd4;
      2'b00:   start_addr = base_q - n4 + 32'd4;
      default: start_addr = base_q - n4;
    endcase
  end

  always_ff @(posedge clk or posedge rst_p) begin
    if (rst_p) begin
      state          <= S_IDLE;
      load_q         <= 1'b0;
      pre_q          <= 1'b0;
      up_q           <= 1'b0;
      wback_q        <= 1'b0;
      base_in_list_q <= 1'b0;
      rn_q           <= 4'd0;
      cur_q          <= 4'd0;
      list_q         <= 16'd0;
      base_q         <= 32'd0;
      wb_val_q       <= 32'd0;
      n_q            <= 5'd0;
      rf_rd_addr     <= 4'd0;
      mem_req        <= 1'b0;
      mem_we         <= 1'b0;
      mem_addr       <= 32'd0;
      busy           <= 1'b0;
      done           <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          load_q         <= load;
          pre_q          <= pre;
          up_q           <= up;
          wback_q        <= wback;
          rn_q           <= rn;
          list_q         <= reg_list;
          base_in_list_q <= reg_list[rn];
          base_q         <= base_value & 32'hFFFF_FFFC;
          busy           <= 1'b1;
          state          <= S_SETUP;
        end
        S_SETUP: begin
          n_q      <= n_c;
          wb_val_q <= up_q ? base_q + n4 : base_q - n4;
          if (n_c != 5'd0) begin
            mem_req    <= 1'b1;
            mem_we     <= ~load_q;
            mem_addr   <= start_addr;
            cur_q      <= lowest16(list_q);
            rf_rd_addr <= load_q ? 4'd0 : lowest16(list_q);
            state      <= S_XFER;
          end else begin
            state <= S_WB;
          end
        end
        // One register per completed access; the next one is presented immediately.
        S_XFER: if (mem_ready) begin
          list_q <= list_nxt;
          if (list_nxt == 16'd0) begin
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= 32'd0;
            cur_q      <= 4'd0;
            rf_rd_addr <= 4'd0;
            state      <= S_WB;
          end else begin
            mem_addr   <= mem_addr + 32'd4;
            cur_q      <= lowest16(list_nxt);
            rf_rd_addr <= load_q ? 4'd0 : lowest16(list_nxt);
          end
        end
        S_WB: begin
          done  <= 1'b1;
          state <= S_DONE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Load data and writeback reach the register file in the completing / WB cycle.
  always_comb begin
    rf_we     = 1'b0;
    rf_wa     = 4'd0;
    rf_wd     = 32'd0;
    pc_load   = 1'b0;
    pc_data   = 32'd0;
    mem_wdata = 32'd0;
    if (state == S_XFER) begin
      if (!load_q) begin
        mem_wdata = rf_rd_data;
      end else if (mem_ready) begin
        if (cur_q == 4'd15) begin
          pc_load = 1'b1;
          pc_data = mem_rdata;
        end else begin
          rf_we = 1'b1;
          rf_wa = cur_q;
          rf_wd = mem_rdata;
        end
      end
    end else if (state == S_WB && wback_q && n_q != 5'd0 && !(load_q && base_in_list_q)) begin
      rf_we = 1'b1;
      rf_wa = rn_q;
      rf_wd = wb_val_q;
    end
  end

endmodule
